// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Shift-and-add 8x8 multiplier (low byte) sequenced over a shared ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] mul_a_i,
    input  logic [7:0] mul_b_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] product_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic       alu_sc_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_out_i,
    input  logic       alu_zero_i
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_AND = 3'b001;
    localparam logic [2:0] c_OP_SRL = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_ADD  = 3'd2,
        S_SHB  = 3'd3,
        S_SHA  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] p_q, p_d;
    logic [7:0] product_q, product_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            p_q       <= 8'h00;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        product_d = product_q;
        alu_a_o   = 8'h00;
        alu_b_o   = 8'h00;
        alu_op_o  = c_OP_ADD;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = mul_a_i;
                    b_d     = mul_b_i;
                    p_d     = 8'h00;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                alu_a_o  = b_q;
                alu_b_o  = 8'h01;
                alu_op_o = c_OP_AND;
                state_d  = alu_zero_i ? S_SHB : S_ADD;
            end
            S_ADD: begin
                alu_a_o  = p_q;
                alu_b_o  = a_q;
                alu_op_o = c_OP_ADD;
                p_d      = alu_out_i;
                state_d  = S_SHB;
            end
            S_SHB: begin
                alu_a_o  = b_q;
                alu_b_o  = 8'h00;
                alu_op_o = c_OP_SRL;
                b_d      = alu_out_i;
                // Multiplier exhausted: p is final, publish it for the Done cycle.
                if (alu_zero_i) begin
                    product_d = p_q;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_SHA;
                end
            end
            S_SHA: begin
                alu_a_o  = a_q;
                alu_b_o  = a_q;
                alu_op_o = c_OP_ADD;
                a_d      = alu_out_i;
                state_d  = S_CHK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q == S_CHK) || (state_q == S_ADD) ||
                       (state_q == S_SHB) || (state_q == S_SHA);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;
    assign alu_sc_o  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
// Module   : tb_alu_mul_seq
// Brief    : Scoreboard bench for alu_mul_seq with a behavioural 8-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sc;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_zero;

    alu_mul_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mul_a_i    (mul_a),
        .mul_b_i    (mul_b),
        .busy_o     (busy),
        .done_o     (done),
        .product_o  (product),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_sc_o   (alu_sc),
        .alu_op_o   (alu_op),
        .alu_out_i  (alu_out),
        .alu_zero_i (alu_zero)
    );

    // Shared ALU: 000 ADD (with SC_in), 001 AND, 010 XOR, 011 SRL of InputA
    always_comb begin
        alu_out = 8'h00;
        case (alu_op)
            3'b000:  alu_out = alu_a + alu_b + {7'b0, alu_sc};
            3'b001:  alu_out = alu_a & alu_b;
            3'b010:  alu_out = alu_a ^ alu_b;
            3'b011:  alu_out = {1'b0, alu_a[7:1]};
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] prod;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass;
    int         n_total;
    logic [2:0] op_log[64];
    int         n_ops;
    int         n_add;

    function automatic int lat_of(input logic [7:0] b);
        int m;
        int pc;
        m  = 1;
        pc = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                m  = i + 1;
                pc = pc + 1;
            end
        end
        return 3 * m + pc;
    endfunction

    // Pulse Start with (a,b) so the next rising edge is E0; returns #1 into cycle 1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit hold);
        exp_t        e;
        logic [15:0] full;
        @(negedge clk);
        mul_a = a;
        mul_b = b;
        start = 1'b1;
        full  = {8'h00, a} * {8'h00, b};
        e.prod = full[7:0];
        e.lat  = lat_of(b);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            mul_a = 8'($urandom);
            mul_b = 8'($urandom);
        end
    endtask

    // Observe from cycle 1 until Done; returns #1 into the cycle after Done.
    task automatic wait_done(output int cyc, output logic [7:0] prod,
                             output bit busy_ok, output bit sc_ok);
        cyc     = -1;
        prod    = 8'h00;
        busy_ok = 1'b1;
        sc_ok   = 1'b1;
        n_ops   = 0;
        n_add   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (alu_sc !== 1'b0) sc_ok = 1'b0;
            if (done === 1'b1) begin
                cyc  = k;
                prod = product;
                if (busy !== 1'b0) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n_ops < 64) op_log[n_ops] = alu_op;
            n_ops = n_ops + 1;
            if (alu_op === 3'b000) n_add = n_add + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mul_a = 8'h00;
        mul_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
        else n_pass++;
        n_total++;
        if (product !== 8'h00) $display("FAIL reset_product: got %h expected 00", product);
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_op, alu_sc} !== 20'h0) $display("FAIL reset_alu_drive: got %h/%h/%b/%b expected 00/00/000/0", alu_a, alu_b, alu_op, alu_sc);
        else n_pass++;
    endtask

    task automatic test_basic();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok, seq_ok;
        exp_t       e;
        logic [2:0] exp_ops[10];
        exp_ops = '{3'b001, 3'b000, 3'b011, 3'b000, 3'b001,
                    3'b011, 3'b000, 3'b001, 3'b000, 3'b011};
        issue(8'd3, 8'd5, 1'b0);
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== 11 || cyc !== e.lat) $display("FAIL basic_done_cycle: got %0d expected 11", cyc);
        else n_pass++;
        n_total++;
        if (prod !== 8'h0F || prod !== e.prod) $display("FAIL basic_product: got %h expected 0f", prod);
        else n_pass++;
        n_total++;
        if (!bok) $display("FAIL basic_busy: busy pattern wrong, got 0 expected 1");
        else n_pass++;
        seq_ok = (n_ops == 10);
        for (int i = 0; i < 10; i++) if (seq_ok && op_log[i] !== exp_ops[i]) seq_ok = 1'b0;
        n_total++;
        if (!seq_ok) $display("FAIL basic_op_sequence: %0d ops, first op %b, expected 10 ops starting 001", n_ops, op_log[0]);
        else n_pass++;
    endtask

    task automatic test_zero_multiplier();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok;
        exp_t       e;
        issue(8'hA7, 8'h00, 1'b0);
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== 3 || cyc !== e.lat) $display("FAIL zero_done_cycle: got %0d expected 3", cyc);
        else n_pass++;
        n_total++;
        if (prod !== 8'h00 || prod !== e.prod) $display("FAIL zero_product: got %h expected 00", prod);
        else n_pass++;
        n_total++;
        if (n_add !== 0) $display("FAIL zero_no_add: got %0d ADD ops expected 0", n_add);
        else n_pass++;
    endtask

    task automatic test_max();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok;
        exp_t       e;
        issue(8'hFF, 8'hFF, 1'b0);
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== 32 || cyc !== e.lat) $display("FAIL max_done_cycle: got %0d expected 32", cyc);
        else n_pass++;
        n_total++;
        if (prod !== 8'h01 || prod !== e.prod) $display("FAIL max_product: got %h expected 01", prod);
        else n_pass++;
    endtask

    task automatic test_start_held();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok;
        exp_t       e;
        logic [15:0] full;
        issue(8'd2, 8'd2, 1'b1);
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== e.lat || prod !== 8'h04) $display("FAIL held_first: cycle %0d product %h expected cycle %0d product 04", cyc, prod, e.lat);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL held_idle_after_done: busy=%b expected 0", busy);
        else n_pass++;
        mul_a = 8'd4;
        mul_b = 8'd3;
        full   = 16'd12;
        e.prod = full[7:0];
        e.lat  = lat_of(8'd3);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== e.lat || prod !== 8'h0C) $display("FAIL held_second: cycle %0d product %h expected cycle %0d product 0c", cyc, prod, e.lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok;
        int         n_done;
        exp_t       e;
        issue(8'd7, 8'd9, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = exp_q.pop_front();
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL midreset_flags: busy/done=%b expected 00", {busy, done});
        else n_pass++;
        n_total++;
        if (product !== 8'h00) $display("FAIL midreset_product: got %h expected 00", product);
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_op} !== 19'h0) $display("FAIL midreset_alu_drive: got %h/%h/%b expected 00/00/000", alu_a, alu_b, alu_op);
        else n_pass++;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk);
            #1;
        end
        n_total++;
        if (n_done !== 0) $display("FAIL midreset_no_done: got %0d Done pulses expected 0", n_done);
        else n_pass++;
        issue(8'd7, 8'd9, 1'b0);
        wait_done(cyc, prod, bok, sok);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== 14 || prod !== 8'h3F || prod !== e.prod) $display("FAIL midreset_restart: cycle %0d product %h expected cycle 14 product 3f", cyc, prod);
        else n_pass++;
    endtask

    task automatic test_random();
        int         cyc;
        logic [7:0] prod;
        bit         bok, sok, sc_all;
        exp_t       e;
        sc_all = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            wait_done(cyc, prod, bok, sok);
            e = exp_q.pop_front();
            if (!sok) sc_all = 1'b0;
            n_total++;
            if (prod !== e.prod) $display("FAIL rand_product[%0d]: got %h expected %h", n, prod, e.prod);
            else n_pass++;
            n_total++;
            if (cyc !== e.lat) $display("FAIL rand_done_cycle[%0d]: got %0d expected %0d", n, cyc, e.lat);
            else n_pass++;
            n_total++;
            if (!bok) $display("FAIL rand_busy[%0d]: busy pattern wrong, got 0 expected 1", n);
            else n_pass++;
        end
        n_total++;
        if (!sc_all || alu_sc !== 1'b0) $display("FAIL rand_alu_sc: got nonzero SC expected 0");
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mul_a   = 8'h00;
        mul_b   = 8'h00;
        test_reset();
        test_basic();
        test_zero_multiplier();
        test_max();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
